// File: rtl/delay_tap_calibrator.sv
// Delay-chain tap calibrator: sweeps taps upward until every trial's return latency meets TARGET, then locks.
// Optional macro DELAY_CAL_CHAIN_RST_EN adds a chain_rst output that flushes the chain between trials.
module delay_tap_calibrator #(
    parameter int TAPS    = 16,
    parameter int TAP_W   = 4,
    parameter int CNT_W   = 8,
    parameter int TARGET  = 6,
    parameter int SAMPLES = 4,
    parameter int TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [TAP_W-1:0] tap_sel,
    output logic             launch,
    input  logic             arrive,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] lat_out
`ifdef DELAY_CAL_CHAIN_RST_EN
    ,
    output logic             chain_rst
`endif
);

    localparam int                 TRIAL_W     = $clog2(SAMPLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]   CNT_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_TARGET  = CNT_W'(TARGET);
    localparam logic [TAP_W-1:0]   TAP_LAST    = TAP_W'(TAPS - 1);
    localparam logic [TRIAL_W-1:0] TRIAL_END   = TRIAL_W'(SAMPLES);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, SETTLE, JUDGE, FIN} state_t;

    state_t               state_q, state_d;
    logic [TAP_W-1:0]     tap_q, tap_d;
    logic                 launch_q, launch_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 fail_q, fail_d;
    logic [CNT_W-1:0]     lat_q, lat_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     min_lat_q, min_lat_d;
    logic [TRIAL_W-1:0]   trial_q, trial_d, trial_inc;
    logic                 sync1_q, sync1_d;
    logic                 arrive_s_q, arrive_s_d;
`ifdef DELAY_CAL_CHAIN_RST_EN
    logic                 chain_rst_q, chain_rst_d;
`endif

    assign trial_inc = trial_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        fail_d     = fail_q;
        lat_d      = lat_q;
        cnt_d      = cnt_q;
        min_lat_d  = min_lat_q;
        trial_d    = trial_q;
        sync1_d    = arrive;
        arrive_s_d = sync1_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    tap_d     = '0;
                    trial_d   = '0;
                    fail_d    = 1'b0;
                    min_lat_d = CNT_MAX;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // An arrival on the same cycle as the timeout still counts as a valid sample.
                if (arrive_s_q) begin
                    if (cnt_q < min_lat_q) begin
                        min_lat_d = cnt_q;
                    end
                    cnt_d   = '0;
                    state_d = SETTLE;
                end else if (cnt_q == CNT_TIMEOUT) begin
                    fail_d  = 1'b1;
                    state_d = FIN;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETTLE: begin
`ifdef DELAY_CAL_CHAIN_RST_EN
                // Two cycles of chain reset followed by two cycles for the synchroniser to drain.
                if (cnt_q == CNT_W'(3)) begin
                    trial_d = trial_inc;
                    state_d = (trial_inc < TRIAL_END) ? LAUNCH : JUDGE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                if (!arrive_s_q) begin
                    trial_d = trial_inc;
                    state_d = (trial_inc < TRIAL_END) ? LAUNCH : JUDGE;
                end else if (cnt_q == CNT_TIMEOUT) begin
                    fail_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            JUDGE: begin
                if (min_lat_q >= CNT_TARGET) begin
                    lat_d   = min_lat_q;
                    state_d = FIN;
                end else if (tap_q == TAP_LAST) begin
                    lat_d   = min_lat_q;
                    fail_d  = 1'b1;
                    state_d = FIN;
                end else begin
                    tap_d     = tap_q + 1'b1;
                    trial_d   = '0;
                    min_lat_d = CNT_MAX;
                    state_d   = LAUNCH;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        launch_d = (state_d == WAIT);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == FIN);
`ifdef DELAY_CAL_CHAIN_RST_EN
        chain_rst_d = (state_d == IDLE) || ((state_d == SETTLE) && (cnt_d < CNT_W'(2)));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tap_q      <= '0;
            launch_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            lat_q      <= '0;
            cnt_q      <= '0;
            min_lat_q  <= CNT_MAX;
            trial_q    <= '0;
            sync1_q    <= 1'b0;
            arrive_s_q <= 1'b0;
`ifdef DELAY_CAL_CHAIN_RST_EN
            chain_rst_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            launch_q   <= launch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fail_q     <= fail_d;
            lat_q      <= lat_d;
            cnt_q      <= cnt_d;
            min_lat_q  <= min_lat_d;
            trial_q    <= trial_d;
            sync1_q    <= sync1_d;
            arrive_s_q <= arrive_s_d;
`ifdef DELAY_CAL_CHAIN_RST_EN
            chain_rst_q <= chain_rst_d;
`endif
        end
    end

    assign tap_sel = tap_q;
    assign launch  = launch_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign fail    = fail_q;
    assign lat_out = lat_q;
`ifdef DELAY_CAL_CHAIN_RST_EN
    assign chain_rst = chain_rst_q;
`endif

endmodule
